fifo_write_arbiter: RTL and testbench

//  Shares the single write port of the sensor-module output FIFO between NUM_REQ byte-stream producers.

---
 rtl/fifo_write_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter for the single write port of the sensor output FIFO.
// Each byte is written once and must be acknowledged before the next; overflow or a missing ack aborts the packet.
module fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   src_data,
  input  logic [NUM_REQ-1:0]     src_last,
  output logic [NUM_REQ-1:0]     src_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [7:0]             fifo_data,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  input  logic                   fifo_write_ack,
  input  logic                   fifo_overflow,
  output logic                   overflow_err,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] sel_idx;
  logic [7:0]    tmo_cnt;
  logic          last_q;
  logic          aborted;

  // Descending scan so the requester closest above rr_ptr overwrites the others.
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      tmo_cnt      <= '0;
      last_q       <= 1'b0;
      aborted      <= 1'b0;
      src_ready    <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      fifo_data    <= '0;
      fifo_wr_en   <= 1'b0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      src_ready  <= '0;
      fifo_wr_en <= 1'b0;
      pkt_done   <= 1'b0;

      // Error sets further down are later assignments, so they win over a same-cycle clear.
      if (clr_err) begin
        overflow_err <= 1'b0;
        timeout_err  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (|req) begin
            grant          <= '0;
            grant[sel_idx] <= 1'b1;
            gnt_idx        <= sel_idx;
            aborted        <= 1'b0;
            busy           <= 1'b1;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (fifo_overflow) begin
            overflow_err <= 1'b1;
            aborted      <= 1'b1;
            state        <= S_DONE;
          end else if (!fifo_full) begin
            fifo_data  <= src_data[{gnt_idx, 3'b000} +: 8];
            fifo_wr_en <= 1'b1;
            last_q     <= src_last[gnt_idx];
            tmo_cnt    <= '0;
            state      <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (fifo_overflow) begin
            overflow_err <= 1'b1;
            aborted      <= 1'b1;
            state        <= S_DONE;
          end else if (fifo_write_ack) begin
            src_ready[gnt_idx] <= 1'b1;
            state              <= last_q ? S_DONE : S_WRITE;
          end else if (tmo_cnt == 8'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_DONE: begin
          if (fifo_overflow) begin
            overflow_err <= 1'b1;
          end
          grant    <= '0;
          busy     <= 1'b0;
          pkt_done <= !aborted && !fifo_overflow;
          rr_ptr   <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: packets are queued per requester, a round-robin model predicts the FIFO byte stream,
// and a negedge monitor checks every write and pkt_done against that prediction.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] src_data;
  logic [NUM_REQ-1:0]   src_last;
  logic [NUM_REQ-1:0]   src_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 pkt_done;
  logic [7:0]           fifo_data;
  logic                 fifo_wr_en;
  logic                 fifo_full;
  logic                 fifo_write_ack;
  logic                 fifo_overflow;
  logic                 overflow_err;
  logic                 timeout_err;
  logic                 clr_err;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  int         exp_done_q[$];
  logic [7:0] pkt [NUM_REQ][$];
  int         rdy_cnt [NUM_REQ];
  int         exp_rdy [NUM_REQ];
  int         n_cmp;
  int         n_err;
  int         m_rr;
  logic [NUM_REQ-1:0] prev_grant;
  logic [NUM_REQ-1:0] last_gnt;

  bit ack_en;
  int ack_min;
  int ack_max;
  int ack_dly;
  bit ack_pending;
  bit ovf_pending;
  int ovf_at;
  int wr_seen;
  bit full_force;
  bit rand_full_en;

  fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .src_data       (src_data),
    .src_last       (src_last),
    .src_ready      (src_ready),
    .grant          (grant),
    .busy           (busy),
    .pkt_done       (pkt_done),
    .fifo_data      (fifo_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .fifo_write_ack (fifo_write_ack),
    .fifo_overflow  (fifo_overflow),
    .overflow_err   (overflow_err),
    .timeout_err    (timeout_err),
    .clr_err        (clr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pkt[i].size() > 0) begin
        src_data[8*i +: 8] = pkt[i][0];
        src_last[i]        = (pkt[i].size() == 1);
      end else begin
        src_data[8*i +: 8] = 8'h00;
        src_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: FIFO side reacts at negedge, producers react just after posedge.
  task automatic tick();
    @(negedge clk);
    fifo_write_ack = 1'b0;
    fifo_overflow  = 1'b0;
    if (fifo_wr_en) begin
      wr_seen++;
      if (ack_en) begin
        ack_pending = 1'b1;
        ack_dly     = $urandom_range(ack_max, ack_min);
        ovf_pending = (wr_seen == ovf_at);
      end
    end
    if (ack_pending) begin
      if (ack_dly == 0) begin
        fifo_write_ack = 1'b1;
        fifo_overflow  = ovf_pending;
        ack_pending    = 1'b0;
        ovf_pending    = 1'b0;
      end else begin
        ack_dly--;
      end
    end
    fifo_full = full_force | (rand_full_en && ($urandom_range(3, 0) == 0));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_ready[i]) begin
        rdy_cnt[i]++;
        if (pkt[i].size() > 0) void'(pkt[i].pop_front());
        if (pkt[i].size() == 0) req[i] = 1'b0;
      end else if (prev_grant[i] && !grant[i] && req[i]) begin
        pkt[i].delete();
        req[i] = 1'b0;
      end
    end
    prev_grant = grant;
    drive();
  endtask

  task automatic fillRandom(input logic [NUM_REQ-1:0] mask, input int maxlen);
    int len;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        pkt[i].delete();
        len = $urandom_range(maxlen, 1);
        for (int j = 0; j < len; j++) pkt[i].push_back(8'($urandom));
      end
    end
  endtask

  // Model: requesters in the mask are served once each, in round-robin order from m_rr.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    int  idx;
    int  last;
    wr_t e;
    last = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_rr + k) % NUM_REQ;
      if (mask[idx]) begin
        for (int j = 0; j < pkt[idx].size(); j++) begin
          e.idx  = idx;
          e.data = pkt[idx][j];
          exp_wr_q.push_back(e);
        end
        exp_done_q.push_back(idx);
        exp_rdy[idx] += pkt[idx].size();
        last = idx;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NUM_REQ;
    req = req | mask;
    drive();
  endtask

  // Single requester whose packet is expected to be cut short after nexp written bytes.
  task automatic launchAborted(input int idx, input int nexp);
    wr_t e;
    for (int j = 0; j < nexp; j++) begin
      e.idx  = idx;
      e.data = pkt[idx][j];
      exp_wr_q.push_back(e);
    end
    exp_rdy[idx] += nexp - 1;
    m_rr = (idx + 1) % NUM_REQ;
    req[idx] = 1'b1;
    drive();
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((req != '0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("round_complete", int'(req == '0 && !busy), 1);
    tick();
  endtask

  task automatic waitWr(input int budget);
    int n;
    n = 0;
    while (!fifo_wr_en && n < budget) begin
      tick();
      n++;
    end
    checkOutput("wr_en_seen", int'(fifo_wr_en), 1);
  endtask

  task automatic endRound();
    checkOutput("pending_writes", exp_wr_q.size(), 0);
    checkOutput("pending_done", exp_done_q.size(), 0);
    checkOutput("grant_idle", int'(grant), 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      checkOutput($sformatf("ready_count_%0d", i), rdy_cnt[i], exp_rdy[i]);
    end
  endtask

  task automatic pulseClear();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or reports a finished packet.
  initial begin
    wr_t e;
    int  d;
    last_gnt = '0;
    forever begin
      @(negedge clk);
      if (grant != '0) last_gnt = grant;
      if (fifo_wr_en) begin
        checkOutput("write_expected", int'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          checkOutput("fifo_data", int'(fifo_data), int'(e.data));
          checkOutput("write_owner", int'(grant), 1 << e.idx);
        end
      end
      if (pkt_done) begin
        checkOutput("done_expected", int'(exp_done_q.size() != 0), 1);
        if (exp_done_q.size() != 0) begin
          d = exp_done_q.pop_front();
          checkOutput("done_owner", int'(last_gnt), 1 << d);
        end
      end
    end
  end

  initial begin
    logic [NUM_REQ-1:0] mask;
    n_cmp = 0; n_err = 0; m_rr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin rdy_cnt[i] = 0; exp_rdy[i] = 0; end
    ack_en = 1'b1; ack_min = 0; ack_max = 2; ack_dly = 0; ack_pending = 1'b0;
    ovf_pending = 1'b0; ovf_at = -1; wr_seen = 0; full_force = 1'b0; rand_full_en = 1'b0;
    reset = 1'b0; req = '0; src_data = '0; src_last = '0; clr_err = 1'b0;
    fifo_full = 1'b0; fifo_write_ack = 1'b0; fifo_overflow = 1'b0; prev_grant = '0;

    repeat (3) tick();
    checkOutput("reset_outputs", int'({src_ready, grant, busy, pkt_done, fifo_data,
                                       fifo_wr_en, overflow_err, timeout_err}), 0);
    reset = 1'b1;
    tick();

    $display("[TB] all four requesters, one-byte packets, then wrap check");
    fillRandom(4'b1111, 1);
    applyStimulus(4'b1111);
    waitIdle(200);
    endRound();
    fillRandom(4'b1001, 1);
    applyStimulus(4'b1001);
    waitIdle(200);
    endRound();

    $display("[TB] single requester, AA then BB");
    pkt[0].delete();
    pkt[0].push_back(8'hAA);
    pkt[0].push_back(8'hBB);
    ack_min = 1; ack_max = 1;
    applyStimulus(4'b0001);
    waitIdle(100);
    endRound();
    ack_min = 0; ack_max = 2;

    $display("[TB] FIFO full stall");
    full_force = 1'b1;
    fillRandom(4'b0001, 1);
    applyStimulus(4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("no_write_while_full", int'(fifo_wr_en), 0);
    end
    checkOutput("grant_during_full", int'(grant), 1);
    full_force = 1'b0;
    tick();
    checkOutput("write_after_full", int'(fifo_wr_en), 1);
    waitIdle(100);
    endRound();

    $display("[TB] ack timeout");
    ack_en = 1'b0;
    fillRandom(4'b0001, 1);
    pkt[0].push_back(8'h5C);
    launchAborted(0, 1);
    waitWr(20);
    for (int k = 1; k <= ACK_TIMEOUT + 1; k++) begin
      tick();
      if (k == ACK_TIMEOUT - 1) checkOutput("timeout_not_early", int'(timeout_err), 0);
      if (k == ACK_TIMEOUT)     checkOutput("timeout_set", int'(timeout_err), 1);
      if (k == ACK_TIMEOUT + 1) checkOutput("grant_cleared", int'(grant), 0);
    end
    waitIdle(50);
    endRound();
    checkOutput("timeout_sticky", int'(timeout_err), 1);
    checkOutput("no_overflow_on_timeout", int'(overflow_err), 0);
    ack_en = 1'b1;
    pulseClear();
    checkOutput("timeout_cleared", int'(timeout_err), 0);

    $display("[TB] overflow together with ack on second byte");
    ack_min = 0; ack_max = 0;
    ovf_at = wr_seen + 2;
    fillRandom(4'b0000, 1);
    pkt[1].delete();
    for (int j = 0; j < 3; j++) pkt[1].push_back(8'($urandom));
    launchAborted(1, 2);
    waitIdle(100);
    endRound();
    ovf_at = -1;
    checkOutput("overflow_set", int'(overflow_err), 1);
    checkOutput("no_timeout_on_overflow", int'(timeout_err), 0);
    pulseClear();
    checkOutput("overflow_cleared", int'(overflow_err), 0);
    ack_min = 0; ack_max = 2;

    $display("[TB] reset during wait for ack");
    fillRandom(4'b0100, 2);
    applyStimulus(4'b0100);
    waitIdle(100);
    endRound();
    ack_en = 1'b0;
    fillRandom(4'b0100, 1);
    launchAborted(2, 1);
    waitWr(20);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs", int'({src_ready, grant, busy, pkt_done, fifo_data,
                                             fifo_wr_en, overflow_err, timeout_err}), 0);
    for (int i = 0; i < NUM_REQ; i++) pkt[i].delete();
    req = '0;
    drive();
    ack_pending = 1'b0;
    ack_en = 1'b1;
    m_rr = 0;
    exp_rdy[2] = rdy_cnt[2];
    tick();
    tick();
    reset = 1'b1;
    tick();
    fillRandom(4'b1010, 3);
    applyStimulus(4'b1010);
    waitIdle(200);
    endRound();

    $display("[TB] randomized rounds");
    rand_full_en = 1'b1;
    ack_min = 0; ack_max = 3;
    for (int r = 0; r < 30; r++) begin
      mask = NUM_REQ'($urandom_range(15, 1));
      fillRandom(mask, 4);
      applyStimulus(mask);
      waitIdle(400);
      endRound();
    end
    rand_full_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
